// File: rtl/tx_mod_if.sv
`default_nettype none
// ============================================================================
//  Module : tx_mod_if
//  Brief  : Host-side handshake bundle for the UART transmitter.
//  Rev    : 1.0  initial release
// ============================================================================
interface tx_mod_if #(
  parameter int NB_DATA = 8
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_tx_data;
  logic               o_tx_done_tick;
  logic               o_tx_busy;

  modport master (
    output i_tx_start,
    output i_tx_data,
    input  o_tx_done_tick,
    input  o_tx_busy
  );

  modport slave (
    input  i_tx_start,
    input  i_tx_data,
    output o_tx_done_tick,
    output o_tx_busy
  );
endinterface
`default_nettype wire

// File: rtl/tx_mod.sv
`default_nettype none
// ============================================================================
//  Module : tx_mod
//  Brief  : UART transmitter, 16x oversampled, LSB first, optional even
//           parity compiled in with the TX_PARITY_EN macro.
//  Rev    : 1.0  initial release
// ============================================================================
module tx_mod #(
  parameter int NB_DATA    = 8,
  parameter int STOP_TICKS = 16
) (
  input  wire logic   i_clk,
  input  wire logic   i_reset,
  input  wire logic   i_s_tick,
  tx_mod_if.slave     bus,
  output logic        o_tx
);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } state_t;

  localparam logic [5:0] c_bit_ticks_last = 6'd15;
  localparam logic [5:0] c_stop_last      = 6'(STOP_TICKS - 1);
  localparam logic [3:0] c_bit_last       = 4'(NB_DATA - 1);

  state_t             r_state;
  logic [5:0]         r_tick;
  logic [3:0]         r_bit;
  logic [NB_DATA-1:0] r_shift;
  logic               r_tx;
  logic [NB_DATA-1:0] w_shift_next;
  logic               w_bit_end;

`ifdef TX_PARITY_EN
  logic               r_parity;
`endif

  assign w_shift_next = r_shift >> 1;
  assign w_bit_end    = i_s_tick && (r_tick == c_bit_ticks_last);

  // The line register is loaded together with the state, so o_tx always
  // reflects the state entered on that edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= TX_IDLE;
      r_tick   <= 6'd0;
      r_bit    <= 4'd0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (bus.i_tx_start) begin
            r_shift  <= bus.i_tx_data;
            r_tick   <= 6'd0;
            r_state  <= TX_START;
            r_tx     <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity <= ^bus.i_tx_data;
`endif
          end
        end

        TX_START: begin
          if (w_bit_end) begin
            r_tick  <= 6'd0;
            r_bit   <= 4'd0;
            r_state <= TX_DATA;
            r_tx    <= r_shift[0];
          end else if (i_s_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end

        TX_DATA: begin
          if (w_bit_end) begin
            r_tick  <= 6'd0;
            r_shift <= w_shift_next;
            if (r_bit == c_bit_last) begin
              r_bit <= 4'd0;
`ifdef TX_PARITY_EN
              r_state <= TX_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 4'd1;
              r_tx  <= w_shift_next[0];
            end
          end else if (i_s_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end

`ifdef TX_PARITY_EN
        TX_PARITY: begin
          if (w_bit_end) begin
            r_tick  <= 6'd0;
            r_state <= TX_STOP;
            r_tx    <= 1'b1;
          end else if (i_s_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end
`endif

        TX_STOP: begin
          r_tx <= 1'b1;
          if (i_s_tick && (r_tick == c_stop_last)) begin
            r_tick  <= 6'd0;
            r_state <= TX_IDLE;
          end else if (i_s_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end

        default: begin
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx               = r_tx;
  assign bus.o_tx_busy      = (r_state != TX_IDLE);
  assign bus.o_tx_done_tick = (r_state == TX_STOP) && i_s_tick && (r_tick == c_stop_last);

endmodule
`default_nettype wire

// File: tb/tb_tx_mod.sv
`default_nettype none
// ============================================================================
//  Module : tb_tx_mod
//  Brief  : Directed, table-driven bench for tx_mod (tick every 4 clocks).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_tx_mod;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
    int          nbits;
    int          frame_ticks;
  } vec_t;

  logic i_clk;
  logic i_reset;
  logic i_s_tick;
  logic o_tx;
  int   total;
  int   bad;
  int   tdiv;

  tx_mod_if #(.NB_DATA(8)) bus ();

  tx_mod #(.NB_DATA(8), .STOP_TICKS(16)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_s_tick (i_s_tick),
    .bus      (bus.slave),
    .o_tx     (o_tx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    i_s_tick = 1'b0;
    tdiv     = 0;
    forever begin
      @(posedge i_clk);
      #1;
      tdiv     = (tdiv + 1) % 4;
      i_s_tick = (tdiv == 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line images list start, data LSB first, [parity,] stop from bit 0 upward.
  function automatic vec_t mkv(input logic [7:0] d, input logic [9:0] l10, input logic [10:0] l11);
    vec_t v;
    v.data = d;
`ifdef TX_PARITY_EN
    v.line        = l11;
    v.nbits       = 11;
    v.frame_ticks = 176;
`else
    v.line        = {1'b0, l10};
    v.nbits       = 10;
    v.frame_ticks = 160;
`endif
    return v;
  endfunction

  task automatic request(input logic [7:0] d, input bit hold);
    @(posedge i_clk);
    #1;
    bus.i_tx_start = 1'b1;
    bus.i_tx_data  = d;
    @(posedge i_clk);
    #1;
    check("accept_tx", {31'd0, o_tx}, 32'd0);
    check("accept_busy", {31'd0, bus.o_tx_busy}, 32'd1);
    if (!hold) begin
      bus.i_tx_start = 1'b0;
      bus.i_tx_data  = ~d;
    end
  endtask

  // Follows one accepted frame tick by tick until its done pulse.
  task automatic watch(input vec_t v, input int inject_tick);
    int         ticks;
    int         dones;
    int         done_at;
    int         pos;
    logic [7:0] word;
    bit         inj;
    ticks   = 0;
    dones   = 0;
    done_at = -1;
    word    = 8'd0;
    inj     = 1'b0;
    for (int cyc = 0; cyc < 4000 && dones == 0; cyc++) begin
      @(negedge i_clk);
      if (inj) begin
        bus.i_tx_start = 1'b0;
        inj            = 1'b0;
      end
      if (!bus.o_tx_busy) break;
      if (bus.o_tx_done_tick) dones++;
      if (i_s_tick) begin
        ticks++;
        pos = ticks / 16;
        if ((ticks % 16 == 8) && (pos < v.nbits)) begin
          check($sformatf("line_%0h_pos%0d", v.data, pos), {31'd0, o_tx}, {31'd0, v.line[pos]});
          if (pos >= 1 && pos <= 8) word[pos-1] = o_tx;
        end
        if (inject_tick != 0 && ticks == inject_tick) begin
          bus.i_tx_start = 1'b1;
          bus.i_tx_data  = 8'h3C;
          inj            = 1'b1;
        end
        if (bus.o_tx_done_tick) done_at = ticks;
      end
    end
    check($sformatf("done_count_%0h", v.data), dones, 32'd1);
    check($sformatf("done_tick_%0h", v.data), done_at, v.frame_ticks);
    check($sformatf("loopback_%0h", v.data), {24'd0, word}, {24'd0, v.data});
  endtask

  task automatic send(input vec_t v, input int inject_tick);
    request(v.data, 1'b0);
    watch(v, inject_tick);
    @(posedge i_clk);
    #1;
    check("end_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    check("end_tx", {31'd0, o_tx}, 32'd1);
  endtask

  vec_t vecs[$];
  vec_t v_a5, v_ff, v_00, v_5a;
  int   ticks;

  initial begin
    total          = 0;
    bad            = 0;
    i_reset        = 1'b1;
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h00;

    v_a5 = mkv(8'hA5, 10'b1101001010, 11'b10101001010);
    v_ff = mkv(8'hFF, 10'b1111111110, 11'b10111111110);
    v_00 = mkv(8'h00, 10'b1000000000, 11'b10000000000);
    v_5a = mkv(8'h5A, 10'b1010110100, 11'b10010110100);
    vecs.push_back(v_a5);
    vecs.push_back(mkv(8'h3C, 10'b1001111000, 11'b10001111000));
    vecs.push_back(mkv(8'h01, 10'b1000000010, 11'b11000000010));
    vecs.push_back(mkv(8'h80, 10'b1100000000, 11'b11100000000));
    vecs.push_back(mkv(8'h07, 10'b1000001110, 11'b11000001110));
    vecs.push_back(mkv(8'h03, 10'b1000000110, 11'b10000000110));

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check("idle_tx", {31'd0, o_tx}, 32'd1);
    check("idle_busy", {31'd0, bus.o_tx_busy}, 32'd0);

    // Reset asserted while idle: outputs settle immediately and stay put.
    @(negedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_tx_done_tick}, 32'd0);
    repeat (3) begin
      @(posedge i_clk);
      #1;
      check("rst_hold_tx", {31'd0, o_tx}, 32'd1);
      check("rst_hold_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    end
    @(negedge i_clk);
    i_reset = 1'b0;

    foreach (vecs[i]) send(vecs[i], 0);

    // Request during data bit 2 of 0xA5 is ignored.
    send(v_a5, 52);

    // Back-to-back with the request held high.
    request(8'hFF, 1'b1);
    watch(v_ff, 0);
    bus.i_tx_data = 8'h00;
    @(posedge i_clk);
    #1;
    check("b2b_gap_tx", {31'd0, o_tx}, 32'd1);
    check("b2b_gap_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    @(posedge i_clk);
    #1;
    check("b2b_accept_tx", {31'd0, o_tx}, 32'd0);
    check("b2b_accept_busy", {31'd0, bus.o_tx_busy}, 32'd1);
    bus.i_tx_start = 1'b0;
    watch(v_00, 0);
    @(posedge i_clk);
    #1;
    check("b2b_end_busy", {31'd0, bus.o_tx_busy}, 32'd0);

    // Abort in the middle of data bit 3 (line low for 0xA5).
    request(8'hA5, 1'b0);
    ticks = 0;
    for (int cyc = 0; cyc < 2000 && ticks < 72; cyc++) begin
      @(negedge i_clk);
      if (i_s_tick) ticks++;
    end
    check("abort_reach", ticks, 32'd72);
    check("abort_pre_tx", {31'd0, o_tx}, 32'd0);
    #1;
    i_reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, o_tx}, 32'd1);
    check("abort_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    check("abort_done", {31'd0, bus.o_tx_done_tick}, 32'd0);
    @(negedge i_clk);
    check("abort_hold_tx", {31'd0, o_tx}, 32'd1);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check("abort_idle_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    send(v_5a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
